// File: rtl/wvb_overflow_ctrl_mc.sv
// Multi-channel waveform buffer overflow controller: per-channel read pointer,
// occupancy, write-inhibit overflow, hysteretic almost-full, sticky flag and onset counter.
module wvb_overflow_ctrl_mc #(
  parameter int N_CHAN      = 4,
  parameter int P_ADR_WIDTH = 12,
  parameter int P_CNT_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_CHAN*P_ADR_WIDTH-1:0]        wvb_wr_addr,
  input  logic [N_CHAN-1:0]                    wvb_rddone,
  input  logic [N_CHAN*P_ADR_WIDTH-1:0]        rd_stop_addr,
  input  logic [N_CHAN-1:0]                    hdr_full,
  input  logic [P_ADR_WIDTH:0]                 hwm_thresh,
  input  logic [P_ADR_WIDTH:0]                 lwm_thresh,
  input  logic [N_CHAN-1:0]                    ovfl_clr,
  output logic [N_CHAN-1:0]                    overflow,
  output logic                                 any_overflow,
  output logic [N_CHAN-1:0]                    almost_full,
  output logic [N_CHAN*(P_ADR_WIDTH+1)-1:0]    wvb_wused,
  output logic [N_CHAN-1:0]                    ovfl_sticky,
  output logic [N_CHAN*P_CNT_WIDTH-1:0]        ovfl_cnt
);

  localparam int AW = P_ADR_WIDTH;
  localparam int UW = P_ADR_WIDTH + 1;
  localparam int CW = P_CNT_WIDTH;

  for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] stop_addr;
    logic [AW-1:0] wr_addr_p1;
    logic [AW-1:0] next_rd_addr;
    logic [AW-1:0] diff;
    logic [UW-1:0] wused_q;
    logic          almost_full_q;
    logic          overflow_q;
    logic          sticky_q;
    logic [CW-1:0] cnt_q;
    logic          onset;

    assign wr_addr    = wvb_wr_addr[i*AW +: AW];
    assign stop_addr  = rd_stop_addr[i*AW +: AW];
    assign wr_addr_p1 = wr_addr + AW'(1);
    // Both subtraction and increment wrap modulo the buffer depth.
    assign diff       = wr_addr - next_rd_addr;

    assign overflow[i] = !rst && (hdr_full[i] || (wr_addr_p1 == next_rd_addr));
    assign onset       = overflow[i] && !overflow_q;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; reset is synchronous, matching the rest of the codebase.
    always_ff @(posedge clk) begin
      if (rst) begin
        next_rd_addr  <= '0;
        wused_q       <= '0;
        almost_full_q <= 1'b0;
        overflow_q    <= 1'b0;
        sticky_q      <= 1'b0;
        cnt_q         <= '0;
      end else begin
        if (wvb_rddone[i])
          next_rd_addr <= stop_addr + AW'(1);

        wused_q <= {1'b0, diff};

        // Set has priority, so overlapping thresholds degrade to a plain compare.
        if (wused_q >= hwm_thresh)
          almost_full_q <= 1'b1;
        else if (wused_q <= lwm_thresh)
          almost_full_q <= 1'b0;

        overflow_q <= overflow[i];

        if (onset)
          sticky_q <= 1'b1;
        else if (ovfl_clr[i])
          sticky_q <= 1'b0;

        if (ovfl_clr[i])
          cnt_q <= onset ? CW'(1) : '0;
        else if (onset && (cnt_q != {CW{1'b1}}))
          cnt_q <= cnt_q + CW'(1);
      end
    end

    assign wvb_wused[i*UW +: UW] = wused_q;
    assign almost_full[i]        = almost_full_q;
    assign ovfl_sticky[i]        = sticky_q;
    assign ovfl_cnt[i*CW +: CW]  = cnt_q;
  end

  assign any_overflow = |overflow;

endmodule

// File: tb/tb_wvb_overflow_ctrl_mc.sv
// Directed self-checking bench for wvb_overflow_ctrl_mc (4 channels, 4-bit
// addresses, 2-bit counters so saturation is reachable).
module tb_wvb_overflow_ctrl_mc;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int UW = AW + 1;
  localparam int CW = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [N*AW-1:0]     wvb_wr_addr;
  logic [N-1:0]        wvb_rddone;
  logic [N*AW-1:0]     rd_stop_addr;
  logic [N-1:0]        hdr_full;
  logic [AW:0]         hwm_thresh;
  logic [AW:0]         lwm_thresh;
  logic [N-1:0]        ovfl_clr;
  logic [N-1:0]        overflow;
  logic                any_overflow;
  logic [N-1:0]        almost_full;
  logic [N*UW-1:0]     wvb_wused;
  logic [N-1:0]        ovfl_sticky;
  logic [N*CW-1:0]     ovfl_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  wvb_overflow_ctrl_mc #(.N_CHAN(N), .P_ADR_WIDTH(AW), .P_CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .wvb_wr_addr  (wvb_wr_addr),
    .wvb_rddone   (wvb_rddone),
    .rd_stop_addr (rd_stop_addr),
    .hdr_full     (hdr_full),
    .hwm_thresh   (hwm_thresh),
    .lwm_thresh   (lwm_thresh),
    .ovfl_clr     (ovfl_clr),
    .overflow     (overflow),
    .any_overflow (any_overflow),
    .almost_full  (almost_full),
    .wvb_wused    (wvb_wused),
    .ovfl_sticky  (ovfl_sticky),
    .ovfl_cnt     (ovfl_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int ch, input logic [AW-1:0] v);
    wvb_wr_addr[ch*AW +: AW] = v;
  endtask

  function automatic logic [UW-1:0] wused_of(input int ch);
    return wvb_wused[ch*UW +: UW];
  endfunction

  function automatic logic [CW-1:0] cnt_of(input int ch);
    return ovfl_cnt[ch*CW +: CW];
  endfunction

  int hys_wr[6] = '{11, 12, 8, 5, 4, 12};
  bit hys_af[6] = '{0, 1, 1, 1, 0, 1};

  initial begin
    rst          = 1'b1;
    wvb_wr_addr  = '0;
    wvb_rddone   = '0;
    rd_stop_addr = '0;
    hdr_full     = '0;
    hwm_thresh   = 5'd12;
    lwm_thresh   = 5'd4;
    ovfl_clr     = '0;

    // Reset / empty
    tick();
    tick();
    check("rst_ovfl_idle", overflow, 4'b0000);
    hdr_full = 4'b1111;
    #1;
    check("rst_ovfl_forced", overflow, 4'b0000);
    check("rst_any_forced", any_overflow, 1'b0);
    hdr_full = '0;
    rst = 1'b0;
    tick();
    check("empty_wused", wvb_wused, '0);
    check("empty_af", almost_full, 4'b0000);
    check("empty_cnt", ovfl_cnt, '0);
    check("empty_sticky", ovfl_sticky, 4'b0000);
    check("empty_ovfl", overflow, 4'b0000);
    check("empty_any", any_overflow, 1'b0);

    // Fill ch2 to full
    for (int w = 0; w < 15; w++) begin
      set_wr(2, w[AW-1:0]);
      tick();
    end
    check("fill14_ovfl", overflow, 4'b0000);
    set_wr(2, 4'd15);
    #1;
    check("full_ovfl", overflow, 4'b0100);
    check("full_any", any_overflow, 1'b1);
    tick();
    check("full_wused2", wused_of(2), 5'd15);
    check("full_sticky", ovfl_sticky, 4'b0100);
    check("full_cnt2", cnt_of(2), 2'd1);
    check("full_wused0", wused_of(0), 5'd0);
    tick();
    check("full_cnt2_hold", cnt_of(2), 2'd1);
    check("full_cnt_others", {cnt_of(3), cnt_of(1), cnt_of(0)}, 6'd0);
    set_wr(2, 4'd0);

    // Wrap on ch0: stop address 15 -> read pointer 0
    set_wr(0, 4'd3);
    rd_stop_addr[0 +: AW] = 4'd15;
    wvb_rddone = 4'b0001;
    tick();
    wvb_rddone = '0;
    tick();
    check("wrap_wused0", wused_of(0), 5'd3);
    check("wrap_ovfl0_low", overflow[0], 1'b0);
    set_wr(0, 4'd15);
    #1;
    check("wrap_ovfl0", overflow[0], 1'b1);
    tick();

    // Hysteresis on ch0 (rd=0), start from a cleared flag
    set_wr(0, 4'd0);
    tick();
    tick();
    check("hys_start_af", almost_full[0], 1'b0);
    for (int k = 0; k < 6; k++) begin
      set_wr(0, hys_wr[k][AW-1:0]);
      tick();
      check($sformatf("hys_wused_%0d", k), wused_of(0), hys_wr[k]);
      if (k > 0) check($sformatf("hys_af_%0d", k - 1), almost_full[0], hys_af[k-1]);
    end
    tick();
    check("hys_af_5", almost_full[0], hys_af[5]);
    set_wr(0, 4'd0);

    // Counter / clear on ch1 via hdr_full
    hdr_full[1] = 1'b1;
    #1;
    check("hdr_ovfl1", overflow[1], 1'b1);
    tick();
    hdr_full[1] = 1'b0; tick();
    hdr_full[1] = 1'b1; tick();
    hdr_full[1] = 1'b1; tick();
    hdr_full[1] = 1'b0; tick();
    check("cnt1_two", cnt_of(1), 2'd2);
    check("sticky1_set", ovfl_sticky[1], 1'b1);
    hdr_full[1] = 1'b1;
    ovfl_clr[1] = 1'b1;
    tick();
    hdr_full[1] = 1'b0;
    ovfl_clr[1] = 1'b0;
    check("clr_onset_cnt1", cnt_of(1), 2'd1);
    check("clr_onset_sticky1", ovfl_sticky[1], 1'b1);
    tick();
    ovfl_clr[1] = 1'b1;
    tick();
    ovfl_clr[1] = 1'b0;
    check("clr_cnt1", cnt_of(1), 2'd0);
    check("clr_sticky1", ovfl_sticky[1], 1'b0);
    for (int k = 0; k < 5; k++) begin
      hdr_full[1] = 1'b1; tick();
      hdr_full[1] = 1'b0; tick();
    end
    check("sat_cnt1", cnt_of(1), 2'd3);

    // Reset mid-operation on ch3: read pointer 9, sticky and almost-full set
    rd_stop_addr[3*AW +: AW] = 4'd8;
    wvb_rddone = 4'b1000;
    tick();
    wvb_rddone = '0;
    set_wr(3, 4'd8);
    #1;
    check("mid_ovfl3", overflow[3], 1'b1);
    tick();
    tick();
    check("mid_wused3", wused_of(3), 5'd15);
    check("mid_sticky3", ovfl_sticky[3], 1'b1);
    check("mid_af3", almost_full[3], 1'b1);
    set_wr(3, 4'd5);
    rst = 1'b1;
    hdr_full[3] = 1'b1;
    #1;
    check("mid_rst_ovfl", overflow, 4'b0000);
    hdr_full[3] = 1'b0;
    tick();
    rst = 1'b0;
    check("post_rst_sticky", ovfl_sticky, 4'b0000);
    check("post_rst_cnt", ovfl_cnt, '0);
    check("post_rst_af", almost_full, 4'b0000);
    tick();
    check("post_rst_wused3", wused_of(3), 5'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wvb_overflow_ctrl_mc.md
Name: wvb_overflow_ctrl_mc

Overview:
Multi-channel waveform buffer overflow controller for the mDOM digitizer. It tracks the read pointer of each channel's circular waveform buffer and reports per-channel occupancy. It asserts an immediate overflow to stop writes, and provides a hysteretic almost-full flag, a sticky overflow flag and a saturating overflow-event counter for slow-control readout. It sits between the per-channel waveform writers, the readout arbiter and the register map.

Parameters:
N_CHAN, 4, number of waveform buffer channels
P_ADR_WIDTH, 12, buffer address width per channel (depth 2^P_ADR_WIDTH)
P_CNT_WIDTH, 16, width of each per-channel overflow event counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wvb_wr_addr  in  N_CHAN*P_ADR_WIDTH  per-channel current write address; channel i at bits [i*P_ADR_WIDTH +: P_ADR_WIDTH]
wvb_rddone  in  N_CHAN  per-channel one-cycle pulse: readout of one event finished
rd_stop_addr  in  N_CHAN*P_ADR_WIDTH  last written address of the event being retired; valid with wvb_rddone
hdr_full  in  N_CHAN  per-channel header FIFO full
hwm_thresh  in  P_ADR_WIDTH+1  almost-full set threshold, shared by all channels
lwm_thresh  in  P_ADR_WIDTH+1  almost-full clear threshold, shared by all channels
ovfl_clr  in  N_CHAN  per-channel clear of sticky flag and counter
overflow  out  N_CHAN  per-channel combinational overflow (write inhibit)
any_overflow  out  1  OR of overflow
almost_full  out  N_CHAN  per-channel hysteretic occupancy flag
wvb_wused  out  N_CHAN*(P_ADR_WIDTH+1)  per-channel registered words used
ovfl_sticky  out  N_CHAN  per-channel latched overflow
ovfl_cnt  out  N_CHAN*P_CNT_WIDTH  per-channel count of overflow onsets

Behaviour:
- Channels are fully independent. No cross-channel interaction except any_overflow.
- Reset: next_rd_addr, wvb_wused, almost_full, ovfl_sticky, ovfl_cnt and the internal overflow_q are all cleared to 0. While rst is high, overflow and any_overflow are forced to 0. A reset mid-operation discards all pointer state on the next edge.
- Read pointer: on a clock edge with wvb_rddone[i], next_rd_addr[i] <= rd_stop_addr[i] + 1, modulo 2^P_ADR_WIDTH. Stop address all-ones wraps to 0.
- Overflow (0 latency, combinational from current regs and inputs):
  - overflow[i] = !rst && (hdr_full[i] || wr_addr[i] + 1 == next_rd_addr[i]), with P_ADR_WIDTH-bit modulo compare.
  - A rddone in the same cycle only affects overflow from the next cycle onward.
- Occupancy: diff = (wr_addr[i] - next_rd_addr[i]) mod 2^P_ADR_WIDTH, zero-extended to P_ADR_WIDTH+1 bits.
  - wvb_wused[i] is registered with 1-cycle latency.
  - Empty (wr == rd) gives 0. Full (wr+1 == rd) gives 2^P_ADR_WIDTH - 1.
- Almost-full, evaluated on registered wvb_wused:
  - If wused >= hwm_thresh, set the flag.
  - Else if wused <= lwm_thresh, clear it.
  - Otherwise hold.
  - Set wins when thresholds overlap (lwm_thresh >= hwm_thresh is legal and behaves as a plain compare).
  - Updates one cycle after wvb_wused, i.e. 2 cycles after a wr/rd change.
- Onset detection: overflow_q[i] <= overflow[i]. Onset = overflow[i] && !overflow_q[i]. A continuous overflow counts once.
- Sticky flag:
  - On onset, set to 1. On ovfl_clr, clear to 0.
  - Onset and ovfl_clr in the same cycle: the flag ends at 1.
- Counter:
  - On onset, increment, saturating at 2^P_CNT_WIDTH - 1.
  - On ovfl_clr, load 0.
  - Onset and ovfl_clr in the same cycle: load 1.
- Outputs ovfl_sticky and ovfl_cnt update on the edge after the onset cycle.

Test Plan:
- Reset/empty, P_ADR_WIDTH=4, N_CHAN=4: rst 2 cycles, all wr_addr=0 -> wvb_wused all 0, overflow=0, almost_full=0, ovfl_cnt=0, any_overflow=0. With rst high and hdr_full=1111 -> overflow=0000.
- Fill to full on ch2: wr_addr[2] ramps 0..15 with no rddone -> at wr=15, overflow[2]=1 in the same cycle and any_overflow=1; wvb_wused[2]=15 one cycle later; ovfl_sticky[2]=1 and ovfl_cnt[2]=1 on the next edge; other channels are unaffected.
- Wrap: ch0 rddone with rd_stop_addr=15 while wr_addr=3 -> next cycle wvb_wused[0]=3. Then wr_addr=15 -> overflow[0]=1 (15+1 wraps to 0 == next_rd_addr).
- Hysteresis, hwm=12, lwm=4: wused sequence 11,12,8,5,4,12 -> almost_full 0,1,1,1,0,1, each lagging wused by one cycle.
- Counter/clear: hdr_full[1] toggles 1,0,1,1,0 (cycle-wise) -> ovfl_cnt[1]=2. ovfl_clr[1] in the same cycle as a third onset -> ovfl_cnt[1]=1, ovfl_sticky[1]=1. With P_CNT_WIDTH=2 and 5 onsets -> ovfl_cnt saturates at 3.
- Reset mid-operation: ch3 with next_rd_addr=9 and sticky set, then assert rst for 1 cycle -> next_rd_addr 0 (checked via wvb_wused[3] = wr_addr[3]); sticky, counter and almost_full all return to 0.
